logic_op_arbiter: RTL and testbench

Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters in the processor datapath. Each request carries an opcode and two operands. A round-robin arbiter grants at most one request per cycle. The result is registered into a single response slot, tagged with the requester ID, and held until the consumer accepts it.

---
 rtl/logic_op_arbiter_if.sv | 39 +++
 rtl/logic_op_arbiter.sv | 98 +++++++++
 tb/tb_logic_op_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle for logic_op_arbiter: two requesters plus one response slot.
// The slave modport is the arbiter's view; the master modport drives requests and consumes responses.
interface logic_op_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin shared AND/OR/XOR/NOR unit for two requesters with a single registered response slot.
// Optional macro LOGIC_OP_ARB_XOR_EN enables XOR/NOR; without it those opcodes return data 0 with rsp_err set.
module logic_op_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  logic_op_arbiter_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             can_accept;
  logic             gnt0, gnt1, gnt_any;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH:0]   op_res;

  // Returns {err, data}; unsupported opcodes yield zero data with err set.
  function automatic logic [WIDTH:0] eval_op(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      2'b00: r = {1'b0, a & b};
      2'b01: r = {1'b0, a | b};
`ifdef LOGIC_OP_ARB_XOR_EN
      2'b10: r = {1'b0, a ^ b};
      default: r = {1'b0, ~(a | b)};
`else
      default: r = {1'b1, {WIDTH{1'b0}}};
`endif
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      prio_q     <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    // A draining slot can be refilled in the same cycle, giving one result per cycle.
    can_accept = (state_q == EMPTY) || bus.rsp_ready;
    gnt1       = can_accept && bus.req1_valid && (!bus.req0_valid || prio_q);
    gnt0       = can_accept && bus.req0_valid && !gnt1;
    gnt_any    = gnt0 || gnt1;

    sel_op = gnt1 ? bus.req1_op : bus.req0_op;
    sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
    sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;
    op_res = eval_op(sel_op, sel_a, sel_b);

    if (gnt_any) begin
      state_d    = FULL;
      rsp_id_d   = gnt1;
      rsp_data_d = op_res[WIDTH-1:0];
      rsp_err_d  = op_res[WIDTH];
      if (bus.req0_valid && bus.req1_valid) begin
        prio_d = ~gnt1;
      end
    end else if (state_q == FULL && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = (state_q == FULL);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter: directed stimulus pushes expected responses,
// a monitor pops and compares on every accepted response.
module tb_logic_op_arbiter;

  logic clock;
  logic reset_n;

  logic_op_arbiter_if #(.WIDTH(32)) bus ();

  logic_op_arbiter #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef LOGIC_OP_ARB_XOR_EN
  localparam logic [31:0] XOR_DATA = 32'h00FF_FF00;
  localparam logic        XOR_ERR  = 1'b0;
  localparam logic [31:0] NOR_DATA = 32'hFFFF_FFFF;
  localparam logic        NOR_ERR  = 1'b0;
`else
  localparam logic [31:0] XOR_DATA = 32'h0000_0000;
  localparam logic        XOR_ERR  = 1'b1;
  localparam logic [31:0] NOR_DATA = 32'h0000_0000;
  localparam logic        NOR_ERR  = 1'b1;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = rr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: every accepted response must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id=%0d data=%0h err=%0d expected none",
                   bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end else begin
          e = sb.pop_front();
          chk("rsp", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, {e.id, e.data, e.err});
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_id",    bus.rsp_id,    1'b0);
    chk("reset_rsp_data",  bus.rsp_data,  32'h0);
    chk("reset_rsp_err",   bus.rsp_err,   1'b0);
    #2 reset_n = 1'b1;

    // Single requester OR
    step();
    drive(1, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 0, 2'b00, 0, 0, 1);
    push(1'b0, 32'hF0F0_0F0F, 1'b0);
    @(negedge clock);
    chk("t1_req0_ready", bus.req0_ready, 1'b1);
    chk("t1_req1_ready", bus.req1_ready, 1'b0);

    // Both valid back-to-back: grants alternate starting from requester 0
    for (int k = 0; k < 4; k++) begin
      step();
      drive(1, 2'b00, 32'hFFFF_0000, 32'h1234_5678, 1, 2'b01, 32'h0000_FFFF, 32'h1234_5678, 1);
      if (k % 2 == 0) push(1'b0, 32'h1234_0000, 1'b0);
      else            push(1'b1, 32'h1234_FFFF, 1'b0);
      @(negedge clock);
      chk($sformatf("t2_req0_ready_%0d", k), bus.req0_ready, (k % 2 == 0));
      chk($sformatf("t2_req1_ready_%0d", k), bus.req1_ready, (k % 2 == 1));
    end
    step();
    drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    step();

    // Stall: slot fills, then holds while rsp_ready is low
    step();
    drive(1, 2'b00, 32'hFFFF_0000, 32'h1234_5678, 1, 2'b01, 32'h0000_FFFF, 32'h1234_5678, 0);
    push(1'b0, 32'h1234_0000, 1'b0);
    @(negedge clock);
    chk("t3_fill_req0_ready", bus.req0_ready, 1'b1);
    chk("t3_fill_req1_ready", bus.req1_ready, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step();
      @(negedge clock);
      chk($sformatf("t3_stall_req0_ready_%0d", s), bus.req0_ready, 1'b0);
      chk($sformatf("t3_stall_req1_ready_%0d", s), bus.req1_ready, 1'b0);
      chk($sformatf("t3_stall_valid_%0d", s), bus.rsp_valid, 1'b1);
      chk($sformatf("t3_stall_payload_%0d", s), {bus.rsp_id, bus.rsp_data, bus.rsp_err},
          {1'b0, 32'h1234_0000, 1'b0});
    end
    step();
    bus.rsp_ready = 1'b1;
    push(1'b1, 32'h1234_FFFF, 1'b0);
    @(negedge clock);
    chk("t3_release_req1_ready", bus.req1_ready, 1'b1);
    chk("t3_release_req0_ready", bus.req0_ready, 1'b0);
    step();
    drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);

    // XOR on requester 1
    step();
    drive(0, 2'b00, 0, 0, 1, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 1);
    push(1'b1, XOR_DATA, XOR_ERR);
    @(negedge clock);
    chk("t4_req1_ready", bus.req1_ready, 1'b1);
    step();
    drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);

    // Asynchronous reset while a result is held
    step();
    drive(1, 2'b00, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 0, 2'b00, 0, 0, 0);
    step();
    drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clock);
    chk("t5_held_valid", bus.rsp_valid, 1'b1);
    chk("t5_held_data",  bus.rsp_data,  32'hA5A5_A5A5);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus.rsp_valid, 1'b0);
    chk("t5_rst_data",  bus.rsp_data,  32'h0);
    #2 reset_n = 1'b1;

    // NOR on requester 1 after reset
    step();
    drive(0, 2'b00, 0, 0, 1, 2'b11, 32'h0, 32'h0, 1);
    push(1'b1, NOR_DATA, NOR_ERR);
    @(negedge clock);
    chk("t5_req1_ready", bus.req1_ready, 1'b1);
    step();
    drive(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
